alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle instruction sequencer for the 8-bit ALU datapath. It accepts one 8-bit instruction per valid/ready handshake and owns a 4-entry register file. It runs each instruction through a fixed DECODE → EXEC → WB sequence: operands go to the external combinational ALU, and the result and flags come back and are written to the destination register. It sits between the instruction source (testbench or future fetch unit) and the ALU.

## Interface
- DATA_W, 8, datapath width; the block is specified and verified at 8 only.
- NREG, 4, register-file depth, addressed by 2-bit fields.

- clk  in  1  rising-edge clock, sole clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- instr_valid  in  1  instruction present on instr.
- instr  in  8  [7:4] opcode, [3:2] rd (also source A), [1:0] rb (source B).
- instr_ready  out  1  registered; high only in IDLE.
- alu_a  out  8  operand A to ALU.
- alu_b  out  8  operand B to ALU.
- alu_opcode  out  4  ALU opcode.
- alu_result  in  8  ALU result, combinational from alu_a/alu_b/alu_opcode.
- alu_zero, alu_carry, alu_overflow  in  1 each  ALU flags.
- result  out  8  last written-back value.
- result_valid  out  1  one-cycle pulse on write-back.
- zero_flag, carry_flag, overflow_flag  out  1 each  registered flags of last write-back.
- err_div0  out  1  one-cycle pulse: DIV/MOD with B = 0.
- err_illegal  out  1  one-cycle pulse: opcode 0x9–0xE.
- busy  out  1  high in DECODE, EXEC, WB.
- dbg_addr  in  2  debug register select.
- dbg_data  out  8  combinational regs[dbg_addr].

## Operation
- Opcodes: 0x0 ADD, 0x1 SUB, 0x2 MUL (low 8 bits), 0x3 DIV, 0x4 MOD, 0x5 AND, 0x6 OR, 0x7 XOR, 0x8 NOT (A only; B still driven). Each maps 1:1 onto alu_opcode. 0xF is NOP. 0x9–0xE are illegal.
- FSM: IDLE → DECODE → EXEC → WB → IDLE. No other transitions except reset.
- IDLE: instr_ready=1. On instr_valid && instr_ready, latch instr, go to DECODE. No acceptance in any other state; instr_valid held while busy is ignored until the next IDLE.
- DECODE: latch opA=regs[rd] and opB=regs[rb] into operand registers. Classify the instruction as ALU, NOP, illegal, or div0 (opcode 0x3/0x4 and opB==0).
- EXEC: drive alu_a=opA, alu_b=opB, alu_opcode=op. Capture alu_result and all three flags into holding registers.
- WB, ALU class: regs[rd]←captured result, result←captured result, flags←captured flags, result_valid=1.
- WB, div0 class: err_div0=1. No register, result or flag update.
- WB, illegal class: err_illegal=1. No register, result or flag update.
- WB, NOP class: no register, result or flag update, and no pulse.
- Outside EXEC: alu_opcode=4'hF, alu_a=0, alu_b=0.
- rd==rb is legal; both operands read the same register value.
- Reset values: regs = {r0=0x01, r1=0x02, r2=0x00, r3=0x00}; state IDLE. All outputs 0: instr_ready, result, flags, pulses, busy, alu_a, alu_b. Exception: alu_opcode=4'hF.
- Reset mid-operation (any state): abort with no write-back, registers return to reset values, no pulse emitted.

## Timing
- Handshake at edge T0. DECODE during cycle T0+1, EXEC during T0+2, WB during T0+3.
- result_valid, err_* and the new register/flag values are visible during T0+3 and take effect at that cycle's closing edge.
- instr_ready is 0 from T0+1 through T0+3, and 1 again in T0+4.
- Throughput: one instruction per 4 cycles.
- instr_ready reset value 0; it rises in the first cycle after rst_n is sampled high.
- Flags hold their value between write-backs.
- dbg_data reflects a write-back from the cycle after the WB edge.

## Test plan
- Reset: hold rst_n=0 for 2 cycles, release → instr_ready=1 next cycle; dbg reads 01,02,00,00; all flags 0; alu_opcode=F.
- ADD r0,r1 (instr 0x01) → result_valid exactly 3 cycles after handshake; result=0x03; r0=0x03; zero=0; instr_ready=0 during busy.
- SUB r2,r2 (0x1A) → result=0x00, zero_flag=1, r2=0x00. Then MUL r1,r1 (0x25) → r1=0x04.
- DIV r0,r2 with r2=0 (0x32) → err_div0 single pulse; no result_valid; r0 and flags unchanged. MOD r1,r0 with r0=1 → r1=0x00, zero=1.
- Illegal 0xA0 → err_illegal pulse, no state change. NOP 0xF0 → no pulse, regs/flags unchanged, instr_ready back after 4 cycles. Back-to-back instr_valid held high → exactly one accept per 4 cycles.
- Reset asserted in EXEC of ADD r0,r1 → no result_valid, r0=0x01 after reset, instr_ready=1 one cycle after release.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Instruction handshake bundle between an instruction source and the ALU sequencer.
// The source drives instr_valid/instr; the sequencer answers with instr_ready.
interface alu_sequencer_if;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle DECODE/EXEC/WB sequencer with a 4-entry register file driving an
// external combinational ALU; one instruction accepted per valid/ready handshake.
module alu_sequencer #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_sequencer_if.slave           instr_if,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [3:0]               alu_opcode,
  input  logic [DATA_W-1:0]        alu_result,
  input  logic                     alu_zero,
  input  logic                     alu_carry,
  input  logic                     alu_overflow,
  output logic [DATA_W-1:0]        result,
  output logic                     result_valid,
  output logic                     zero_flag,
  output logic                     carry_flag,
  output logic                     overflow_flag,
  output logic                     err_div0,
  output logic                     err_illegal,
  output logic                     busy,
  input  logic [$clog2(NREG)-1:0]  dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam logic [DATA_W-1:0] ZERO_W = {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    C_ALU  = 2'd0,
    C_NOP  = 2'd1,
    C_ILL  = 2'd2,
    C_DIV0 = 2'd3
  } cls_e;

  function automatic cls_e classify(input logic [3:0] op, input logic [DATA_W-1:0] b);
    cls_e c;
    case (op)
      4'h3, 4'h4:                               c = (b == ZERO_W) ? C_DIV0 : C_ALU;
      4'h0, 4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8: c = C_ALU;
      4'hF:                                     c = C_NOP;
      default:                                  c = C_ILL;
    endcase
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] reg_reset_val(input int idx);
    logic [DATA_W-1:0] v;
    case (idx)
      32'sd0:  v = DATA_W'(1);
      32'sd1:  v = DATA_W'(2);
      default: v = ZERO_W;
    endcase
    return v;
  endfunction

  state_e            state_q, state_d;
  cls_e              cls_q, cls_d;
  cls_e              cls_s;
  logic [7:0]        instr_q, instr_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [2:0]        flags_q, flags_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              rv_q, rv_d;
  logic              div0_q, div0_d;
  logic              ill_q, ill_d;
  logic [DATA_W-1:0] regs_q [NREG];

  logic              accept_s;
  logic              wb_en_s;
  logic [1:0]        rd_s;
  logic [1:0]        rb_s;
  logic [DATA_W-1:0] opa_s;
  logic [DATA_W-1:0] opb_s;

  // Field decode, operand read and handshake qualification
  always_comb begin
    rd_s     = instr_q[3:2];
    rb_s     = instr_q[1:0];
    opa_s    = regs_q[rd_s];
    opb_s    = regs_q[rb_s];
    cls_s    = classify(instr_q[7:4], opb_s);
    accept_s = instr_if.instr_valid & ready_q;
    wb_en_s  = (state_q == S_WB) && (cls_q == C_ALU);
  end

  // FSM next state; the only branch point is acceptance in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = accept_s ? S_DECODE : S_IDLE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next values; outputs are computed one cycle early so they register in step with the state
  always_comb begin
    instr_d  = instr_q;
    cls_d    = cls_q;
    alu_a_d  = ZERO_W;
    alu_b_d  = ZERO_W;
    alu_op_d = 4'hF;
    hold_d   = hold_q;
    result_d = result_q;
    flags_d  = flags_q;
    rv_d     = 1'b0;
    div0_d   = 1'b0;
    ill_d    = 1'b0;
    ready_d  = (state_d == S_IDLE);
    busy_d   = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        instr_d = accept_s ? instr_if.instr : instr_q;
      end
      S_DECODE: begin
        alu_a_d  = opa_s;
        alu_b_d  = opb_s;
        alu_op_d = instr_q[7:4];
        cls_d    = cls_s;
      end
      S_EXEC: begin
        // Result and flags are published together with the write-back pulse
        hold_d   = alu_result;
        rv_d     = (cls_q == C_ALU);
        div0_d   = (cls_q == C_DIV0);
        ill_d    = (cls_q == C_ILL);
        result_d = (cls_q == C_ALU) ? alu_result : result_q;
        flags_d  = (cls_q == C_ALU) ? {alu_zero, alu_carry, alu_overflow} : flags_q;
      end
      S_WB: begin
        cls_d = cls_q;
      end
      default: begin
        cls_d = cls_q;
      end
    endcase
  end

  // Control and datapath state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cls_q    <= C_NOP;
      instr_q  <= 8'h00;
      alu_a_q  <= ZERO_W;
      alu_b_q  <= ZERO_W;
      alu_op_q <= 4'hF;
      hold_q   <= ZERO_W;
      result_q <= ZERO_W;
      flags_q  <= 3'b000;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      rv_q     <= 1'b0;
      div0_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      instr_q  <= instr_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      hold_q   <= hold_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      rv_q     <= rv_d;
      div0_q   <= div0_d;
      ill_q    <= ill_d;
    end
  end

  // Register file; only an ALU-class write-back modifies it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= reg_reset_val(i);
      end
    end else if (wb_en_s) begin
      regs_q[instr_q[3:2]] <= hold_q;
    end
  end

  assign instr_if.instr_ready = ready_q;
  assign alu_a                = alu_a_q;
  assign alu_b                = alu_b_q;
  assign alu_opcode           = alu_op_q;
  assign result               = result_q;
  assign result_valid         = rv_q;
  assign zero_flag            = flags_q[2];
  assign carry_flag           = flags_q[1];
  assign overflow_flag        = flags_q[0];
  assign err_div0             = div0_q;
  assign err_illegal          = ill_q;
  assign busy                 = busy_q;
  assign dbg_data             = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vector table, multi-cycle corner
// sequences and random instructions against an instruction-level reference model.
module tb_alu_sequencer;

  localparam int K_ALU  = 0;
  localparam int K_NOP  = 1;
  localparam int K_ILL  = 2;
  localparam int K_DIV0 = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] alu_a, alu_b, alu_result, result, dbg_data;
  logic [3:0] alu_opcode;
  logic       alu_zero, alu_carry, alu_overflow;
  logic       result_valid, zero_flag, carry_flag, overflow_flag;
  logic       err_div0, err_illegal, busy;
  logic [1:0] dbg_addr;

  int n_chk = 0;
  int n_err = 0;
  int obs_kind;

  logic [7:0] m_regs [4];
  logic [7:0] m_res;
  logic       m_z, m_c, m_v;

  alu_sequencer_if ifc ();

  alu_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_if      (ifc),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_opcode    (alu_opcode),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .alu_carry     (alu_carry),
    .alu_overflow  (alu_overflow),
    .result        (result),
    .result_valid  (result_valid),
    .zero_flag     (zero_flag),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag),
    .err_div0      (err_div0),
    .err_illegal   (err_illegal),
    .busy          (busy),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
  );

  always #10 clk = ~clk;

  // Returns {overflow, carry, zero, result[7:0]}
  function automatic logic [10:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0]  w;
    logic [15:0] p;
    logic [7:0]  r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'h0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'h1: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'h2: begin p = a * b; r = p[7:0]; c = (p[15:8] != 8'h00); end
      4'h3: r = (b == 8'h00) ? 8'h00 : a / b;
      4'h4: r = (b == 8'h00) ? 8'h00 : a % b;
      4'h5: r = a & b;
      4'h6: r = a | b;
      4'h7: r = a ^ b;
      4'h8: r = ~a;
      default: r = 8'h00;
    endcase
    return {v, c, (r == 8'h00), r};
  endfunction

  always_comb {alu_overflow, alu_carry, alu_zero, alu_result} = ref_alu(alu_opcode, alu_a, alu_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_regs[0] = 8'h01; m_regs[1] = 8'h02; m_regs[2] = 8'h00; m_regs[3] = 8'h00;
    m_res = 8'h00; m_z = 1'b0; m_c = 1'b0; m_v = 1'b0;
  endtask

  task automatic dbg_check();
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk($sformatf("dbg_r%0d", i), dbg_data, m_regs[i]);
    end
  endtask

  task automatic flags_check();
    chk("result_hold", result, m_res);
    chk("zero_flag", zero_flag, m_z);
    chk("carry_flag", carry_flag, m_c);
    chk("ovf_flag", overflow_flag, m_v);
  endtask

  task automatic run_instr(input logic [7:0] ins);
    logic [3:0]  op;
    logic [1:0]  rd, rb;
    logic [7:0]  a, b;
    logic [10:0] ar;
    int          kind;
    int          waitc;
    op = ins[7:4]; rd = ins[3:2]; rb = ins[1:0];
    @(negedge clk);
    ifc.instr_valid = 1'b1;
    ifc.instr       = ins;
    waitc = 0;
    while (ifc.instr_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (ifc.instr_ready !== 1'b1) begin
      chk("ready_timeout", ifc.instr_ready, 1);
      ifc.instr_valid = 1'b0;
      return;
    end
    a  = m_regs[rd];
    b  = m_regs[rb];
    ar = ref_alu(op, a, b);
    if (op == 4'hF)                                      kind = K_NOP;
    else if (op > 4'h8)                                  kind = K_ILL;
    else if ((op == 4'h3 || op == 4'h4) && b == 8'h00)   kind = K_DIV0;
    else                                                 kind = K_ALU;
    @(posedge clk);
    #1;
    ifc.instr_valid = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      chk($sformatf("ready_c%0d", cyc), ifc.instr_ready, (cyc == 4) ? 1 : 0);
      chk($sformatf("busy_c%0d", cyc), busy, (cyc == 4) ? 0 : 1);
      if (cyc == 2) begin
        chk("exec_opcode", alu_opcode, op);
        chk("exec_a", alu_a, a);
        chk("exec_b", alu_b, b);
      end else begin
        chk("idle_opcode", alu_opcode, 4'hF);
        chk("idle_ab", {alu_a, alu_b}, 16'h0000);
      end
      if (cyc == 3) begin
        chk("result_valid", result_valid, kind == K_ALU);
        chk("err_div0", err_div0, kind == K_DIV0);
        chk("err_illegal", err_illegal, kind == K_ILL);
        if (kind == K_ALU) chk("wb_result", result, ar[7:0]);
        obs_kind = result_valid ? K_ALU : err_div0 ? K_DIV0 : err_illegal ? K_ILL : K_NOP;
      end else begin
        chk("no_pulse", {result_valid, err_div0, err_illegal}, 3'b000);
      end
    end
    if (kind == K_ALU) begin
      m_regs[rd] = ar[7:0];
      m_res      = ar[7:0];
      {m_v, m_c, m_z} = ar[10:8];
    end
    flags_check();
    dbg_check();
  endtask

  typedef struct packed {
    logic [7:0] ins;
    logic [1:0] kind;
    logic [7:0] exp_res;
    logic [7:0] exp_rd;
    logic       exp_z;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    int last;
    int pulses;

    vecs[0]  = '{8'h01, 2'd0, 8'h03, 8'h03, 1'b0};
    vecs[1]  = '{8'h1A, 2'd0, 8'h00, 8'h00, 1'b1};
    vecs[2]  = '{8'h25, 2'd0, 8'h04, 8'h04, 1'b0};
    vecs[3]  = '{8'h32, 2'd3, 8'h00, 8'h03, 1'b0};
    vecs[4]  = '{8'h30, 2'd0, 8'h01, 8'h01, 1'b0};
    vecs[5]  = '{8'h44, 2'd0, 8'h00, 8'h00, 1'b1};
    vecs[6]  = '{8'hA0, 2'd2, 8'h00, 8'h01, 1'b1};
    vecs[7]  = '{8'hF0, 2'd1, 8'h00, 8'h01, 1'b1};
    vecs[8]  = '{8'h8C, 2'd0, 8'hFF, 8'hFF, 1'b0};
    vecs[9]  = '{8'h5F, 2'd0, 8'hFF, 8'hFF, 1'b0};
    vecs[10] = '{8'h6B, 2'd0, 8'hFF, 8'hFF, 1'b0};
    vecs[11] = '{8'h0F, 2'd0, 8'hFE, 8'hFE, 1'b0};
    vecs[12] = '{8'h1E, 2'd0, 8'hFF, 8'hFF, 1'b0};
    vecs[13] = '{8'h71, 2'd0, 8'h01, 8'h01, 1'b0};
    vecs[14] = '{8'h4C, 2'd0, 8'h00, 8'h00, 1'b1};
    vecs[15] = '{8'hE5, 2'd2, 8'h00, 8'h00, 1'b1};

    rst_n = 1'b0;
    ifc.instr_valid = 1'b0;
    ifc.instr = 8'h00;
    dbg_addr = 2'd0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ifc.instr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_opcode", alu_opcode, 4'hF);
    chk("rst_ab", {alu_a, alu_b}, 16'h0000);
    chk("rst_pulses", {result_valid, err_div0, err_illegal}, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", ifc.instr_ready, 1);
    flags_check();
    dbg_check();

    // Directed table
    for (int i = 0; i < 16; i++) begin
      run_instr(vecs[i].ins);
      chk($sformatf("tbl%0d_kind", i), obs_kind, vecs[i].kind);
      chk($sformatf("tbl%0d_zero", i), zero_flag, vecs[i].exp_z);
      if (vecs[i].kind == 2'd0) chk($sformatf("tbl%0d_res", i), result, vecs[i].exp_res);
      dbg_addr = vecs[i].ins[3:2];
      #1;
      chk($sformatf("tbl%0d_rd", i), dbg_data, vecs[i].exp_rd);
    end

    // Back-to-back: instr_valid held high accepts exactly once every 4 cycles
    @(negedge clk);
    ifc.instr = 8'hF0;
    ifc.instr_valid = 1'b1;
    accepts = 0;
    last = -1;
    pulses = 0;
    for (int c = 0; c < 16; c++) begin
      if (ifc.instr_ready === 1'b1) begin
        if (last >= 0) chk("b2b_gap", c - last, 4);
        last = c;
        accepts++;
      end
      pulses += int'(result_valid) + int'(err_div0) + int'(err_illegal);
      @(negedge clk);
    end
    ifc.instr_valid = 1'b0;
    chk("b2b_accepts", accepts, 4);
    chk("b2b_nop_pulses", pulses, 0);
    flags_check();
    dbg_check();

    // Random instructions against the reference model
    for (int i = 0; i < 60; i++) begin
      run_instr(8'($urandom_range(0, 255)));
    end

    // Reset asserted during EXEC of ADD r0,r1
    @(negedge clk);
    ifc.instr = 8'h01;
    ifc.instr_valid = 1'b1;
    last = 0;
    while (ifc.instr_ready !== 1'b1 && last < 20) begin
      @(negedge clk);
      last++;
    end
    chk("mid_ready_wait", ifc.instr_ready, 1);
    @(posedge clk);
    #1;
    ifc.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_in_exec", alu_opcode, 4'h0);
    rst_n = 1'b0;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      pulses += int'(result_valid) + int'(err_div0) + int'(err_illegal);
    end
    chk("mid_rst_ready", ifc.instr_ready, 0);
    chk("mid_rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    pulses += int'(result_valid) + int'(err_div0) + int'(err_illegal);
    chk("mid_no_pulse", pulses, 0);
    chk("mid_rel_ready", ifc.instr_ready, 1);
    model_reset();
    flags_check();
    dbg_check();
    run_instr(8'h01);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
